// File: rtl/chopper_pkg.sv
// Shared types and widths for the per-coil chopper timer sequencer.
// Both channel FSMs and the top level import this package.
package chopper_pkg;

   localparam int BLANK_W = 8;
   localparam int MINON_W = 8;
   localparam int OFF_W   = 10;
   localparam int PRESC_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      ON    = 2'd2,
      OFF   = 2'd3
   } chop_state_t;

endpackage

// File: rtl/chopper_channel.sv
// One coil's chopper FSM: blank / minimum-on / off timers
// and a saturating count of OFF entries.
module chopper_channel
   import chopper_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic               tick,
   input  logic               step_restart,
   input  logic               offtimer_en,
   input  logic               stats_clear,
   input  logic [BLANK_W-1:0] cfg_blank,
   input  logic [MINON_W-1:0] cfg_min_on,
   input  logic [OFF_W-1:0]   cfg_off_time,
   output logic [BLANK_W-1:0] blank_timer,
   output logic [MINON_W-1:0] minimum_on_timer,
   output logic [OFF_W-1:0]   off_timer,
   output logic [1:0]         chop_state,
   output logic [CNT_W-1:0]   chop_count
);

   chop_state_t        state_q, state_d;
   logic [BLANK_W-1:0] blank_q, blank_d, blank_dec;
   logic [MINON_W-1:0] minon_q, minon_d, minon_dec;
   logic [OFF_W-1:0]   off_q, off_d, off_dec;
   logic [CNT_W-1:0]   count_q, count_d, count_inc;
   logic               reload;

   assign blank_dec = (tick && blank_q != '0) ? blank_q - 1'b1 : blank_q;
   assign minon_dec = (tick && minon_q != '0) ? minon_q - 1'b1 : minon_q;
   assign off_dec   = (off_q != '0) ? off_q - 1'b1 : off_q;
   assign count_inc = (count_q == '1) ? count_q : count_q + 1'b1;

   always_comb begin
      state_d = state_q;
      blank_d = blank_q;
      minon_d = minon_q;
      off_d   = off_q;
      count_d = count_q;
      reload  = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         blank_d = '0;
         minon_d = '0;
         off_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: reload = 1'b1;
            BLANK: begin
               blank_d = blank_dec;
               minon_d = minon_dec;
               if (blank_q == '0) state_d = ON;
            end
            ON: begin
               minon_d = minon_dec;
               if (step_restart) begin
                  reload = 1'b1;
               end else if (offtimer_en && cfg_off_time != '0) begin
                  state_d = OFF;
                  off_d   = cfg_off_time;
                  count_d = count_inc;
               end
            end
            OFF: begin
               if (step_restart) begin
                  reload = 1'b1;
               end else if (tick) begin
                  minon_d = minon_dec;
                  off_d   = off_dec;
                  if (off_q <= OFF_W'(1)) reload = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // min_on deliberately survives OFF entry; only a reload restarts it
      if (reload) begin
         state_d = BLANK;
         blank_d = cfg_blank;
         minon_d = cfg_min_on;
         off_d   = '0;
      end
      if (stats_clear) count_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         blank_q <= '0;
         minon_q <= '0;
         off_q   <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         blank_q <= blank_d;
         minon_q <= minon_d;
         off_q   <= off_d;
         count_q <= count_d;
      end
   end

   assign blank_timer      = blank_q;
   assign minimum_on_timer = minon_q;
   assign off_timer        = off_q;
   assign chop_state       = state_q;
   assign chop_count       = count_q;

endmodule

// File: rtl/chopper_timer_sequencer.sv
// Two-coil chopper timer sequencer: shared tick prescaler and
// commutation step detection feeding one FSM per coil.
module chopper_timer_sequencer
   import chopper_pkg::*;
#(
   parameter int CLK_DIV = 1,
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [7:0]         phase_ct,
   input  logic               offtimer_en0,
   input  logic               offtimer_en1,
   input  logic [BLANK_W-1:0] cfg_blank,
   input  logic [MINON_W-1:0] cfg_min_on,
   input  logic [OFF_W-1:0]   cfg_off_time,
   input  logic               cfg_step_restart,
   input  logic               stats_clear,
   output logic [BLANK_W-1:0] blank_timer0,
   output logic [BLANK_W-1:0] blank_timer1,
   output logic [MINON_W-1:0] minimum_on_timer0,
   output logic [MINON_W-1:0] minimum_on_timer1,
   output logic [OFF_W-1:0]   off_timer0,
   output logic [OFF_W-1:0]   off_timer1,
   output logic [1:0]         chop_state0,
   output logic [1:0]         chop_state1,
   output logic [CNT_W-1:0]   chop_count0,
   output logic [CNT_W-1:0]   chop_count1
);

   localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_DIV - 1);

   logic [PRESC_W-1:0] presc_q;
   logic [7:0]         phase_q;
   logic               tick;
   logic               step_evt;
   logic               step_restart;

   assign tick         = (presc_q == PRESC_MAX);
   assign step_evt     = (phase_ct != phase_q);
   assign step_restart = cfg_step_restart & step_evt;

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         phase_q <= '0;
      end else begin
         presc_q <= tick ? '0 : presc_q + 1'b1;
         phase_q <= phase_ct;
      end
   end

   chopper_channel #(.CNT_W(CNT_W)) u_ch0 (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .tick             (tick),
      .step_restart     (step_restart),
      .offtimer_en      (offtimer_en0),
      .stats_clear      (stats_clear),
      .cfg_blank        (cfg_blank),
      .cfg_min_on       (cfg_min_on),
      .cfg_off_time     (cfg_off_time),
      .blank_timer      (blank_timer0),
      .minimum_on_timer (minimum_on_timer0),
      .off_timer        (off_timer0),
      .chop_state       (chop_state0),
      .chop_count       (chop_count0)
   );

   chopper_channel #(.CNT_W(CNT_W)) u_ch1 (
      .clk              (clk),
      .reset            (reset),
      .enable           (enable),
      .tick             (tick),
      .step_restart     (step_restart),
      .offtimer_en      (offtimer_en1),
      .stats_clear      (stats_clear),
      .cfg_blank        (cfg_blank),
      .cfg_min_on       (cfg_min_on),
      .cfg_off_time     (cfg_off_time),
      .blank_timer      (blank_timer1),
      .minimum_on_timer (minimum_on_timer1),
      .off_timer        (off_timer1),
      .chop_state       (chop_state1),
      .chop_count       (chop_count1)
   );

endmodule

// File: tb/tb_chopper_timer_sequencer.sv
// Bench for chopper_timer_sequencer: a divide-by-1 and a divide-by-4
// instance share stimulus and are tracked by a behavioural model.
module tb_chopper_timer_sequencer;

   logic       clk = 1'b0;
   logic       reset = 1'b1, enable = 1'b0;
   logic       off_en0 = 1'b0, off_en1 = 1'b0;
   logic       cfg_step_restart = 1'b0, stats_clear = 1'b0;
   logic [7:0] phase_ct = 8'd0, cfg_blank = 8'd4, cfg_min_on = 8'd10;
   logic [9:0] cfg_off_time = 10'd20;

   logic [7:0]  a_bt0, a_bt1, a_mt0, a_mt1, b_bt0, b_bt1, b_mt0, b_mt1;
   logic [9:0]  a_ot0, a_ot1, b_ot0, b_ot1;
   logic [1:0]  a_st0, a_st1, b_st0, b_st1;
   logic [15:0] a_cc0, a_cc1;
   logic [3:0]  b_cc0, b_cc1;

   always #5 clk = ~clk;

   chopper_timer_sequencer #(.CLK_DIV(1), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .enable(enable), .phase_ct(phase_ct),
      .offtimer_en0(off_en0), .offtimer_en1(off_en1),
      .cfg_blank(cfg_blank), .cfg_min_on(cfg_min_on),
      .cfg_off_time(cfg_off_time), .cfg_step_restart(cfg_step_restart),
      .stats_clear(stats_clear),
      .blank_timer0(a_bt0), .blank_timer1(a_bt1),
      .minimum_on_timer0(a_mt0), .minimum_on_timer1(a_mt1),
      .off_timer0(a_ot0), .off_timer1(a_ot1),
      .chop_state0(a_st0), .chop_state1(a_st1),
      .chop_count0(a_cc0), .chop_count1(a_cc1)
   );

   chopper_timer_sequencer #(.CLK_DIV(4), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .enable(enable), .phase_ct(phase_ct),
      .offtimer_en0(off_en0), .offtimer_en1(off_en1),
      .cfg_blank(cfg_blank), .cfg_min_on(cfg_min_on),
      .cfg_off_time(cfg_off_time), .cfg_step_restart(cfg_step_restart),
      .stats_clear(stats_clear),
      .blank_timer0(b_bt0), .blank_timer1(b_bt1),
      .minimum_on_timer0(b_mt0), .minimum_on_timer1(b_mt1),
      .off_timer0(b_ot0), .off_timer1(b_ot1),
      .chop_state0(b_st0), .chop_state1(b_st1),
      .chop_count0(b_cc0), .chop_count1(b_cc1)
   );

   int total = 0;
   int bad = 0;

   // model: mode 0 idle, 1 blanking, 2 on, 3 off
   typedef struct {
      int mode; int blank; int minon; int off; int cnt;
   } mch_t;

   mch_t mdl [2][2];
   int   pre [2];
   int   phq = 0;
   int   div_of [2] = '{1, 4};
   int   cmax [2] = '{65535, 15};

   function automatic logic [63:0] pk(int s, int b, int m, int o, int c);
      return {20'd0, s[1:0], b[7:0], m[7:0], o[9:0], c[15:0]};
   endfunction

   function automatic logic [63:0] act(int d, int c);
      if (d == 0 && c == 0)
         return pk(int'(a_st0), int'(a_bt0), int'(a_mt0), int'(a_ot0), int'(a_cc0));
      if (d == 0)
         return pk(int'(a_st1), int'(a_bt1), int'(a_mt1), int'(a_ot1), int'(a_cc1));
      if (c == 0)
         return pk(int'(b_st0), int'(b_bt0), int'(b_mt0), int'(b_ot0), int'(b_cc0));
      return pk(int'(b_st1), int'(b_bt1), int'(b_mt1), int'(b_ot1), int'(b_cc1));
   endfunction

   task automatic check(string nm, logic [63:0] a, logic [63:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", nm, a, e);
      end
   endtask

   function automatic mch_t ch_next(mch_t c, bit tk, bit stp, bit trip, int cm);
      mch_t n = c;
      bit rl = 0;
      if (!enable) begin
         n.mode = 0; n.blank = 0; n.minon = 0; n.off = 0;
      end else if (c.mode == 0) begin
         rl = 1;
      end else if (c.mode == 1) begin
         if (tk && c.blank > 0) n.blank = c.blank - 1;
         if (tk && c.minon > 0) n.minon = c.minon - 1;
         if (c.blank == 0) n.mode = 2;
      end else if (stp) begin
         rl = 1;
      end else if (c.mode == 2) begin
         if (tk && c.minon > 0) n.minon = c.minon - 1;
         if (trip && cfg_off_time != 0) begin
            n.mode = 3;
            n.off = int'(cfg_off_time);
            n.cnt = (c.cnt < cm) ? c.cnt + 1 : cm;
         end
      end else if (tk) begin
         if (c.minon > 0) n.minon = c.minon - 1;
         n.off = c.off - 1;
         if (n.off <= 0) rl = 1;
      end
      if (rl) begin
         n.mode = 1; n.blank = int'(cfg_blank);
         n.minon = int'(cfg_min_on); n.off = 0;
      end
      if (stats_clear) n.cnt = 0;
      return n;
   endfunction

   task automatic cyc();
      mch_t nx [2][2];
      int   npre [2];
      bit   stp, tk;
      stp = cfg_step_restart && (int'(phase_ct) != phq);
      for (int d = 0; d < 2; d++) begin
         tk = (pre[d] == div_of[d] - 1);
         npre[d] = tk ? 0 : pre[d] + 1;
         nx[d][0] = ch_next(mdl[d][0], tk, stp, off_en0, cmax[d]);
         nx[d][1] = ch_next(mdl[d][1], tk, stp, off_en1, cmax[d]);
         if (reset) begin
            npre[d] = 0;
            for (int c = 0; c < 2; c++) nx[d][c] = '{0, 0, 0, 0, 0};
         end
      end
      @(posedge clk);
      #1;
      phq = reset ? 0 : int'(phase_ct);
      for (int d = 0; d < 2; d++) begin
         pre[d] = npre[d];
         for (int c = 0; c < 2; c++) begin
            mdl[d][c] = nx[d][c];
            check($sformatf("model_d%0d_c%0d", d, c), act(d, c),
                  pk(mdl[d][c].mode, mdl[d][c].blank, mdl[d][c].minon,
                     mdl[d][c].off, mdl[d][c].cnt));
         end
      end
   endtask

   task automatic wait_st(int d, int st, string nm);
      int n = 0;
      while (int'(act(d, 0) >> 42) != st && n < 100) begin
         cyc();
         n++;
      end
      check(nm, 64'(n < 100), 64'd1);
   endtask

   typedef struct {
      bit rst; bit en; bit trip;
      int st; int b; int m; int o; int c;
   } vec_t;

   vec_t tv [12];

   initial begin
      int n;
      tv[0]  = '{1, 0, 0, 0, 0, 0, 0, 0};
      tv[1]  = '{0, 1, 0, 1, 4, 10, 0, 0};
      tv[2]  = '{0, 1, 0, 1, 3, 9, 0, 0};
      tv[3]  = '{0, 1, 0, 1, 2, 8, 0, 0};
      tv[4]  = '{0, 1, 0, 1, 1, 7, 0, 0};
      tv[5]  = '{0, 1, 0, 1, 0, 6, 0, 0};
      tv[6]  = '{0, 1, 0, 2, 0, 5, 0, 0};
      tv[7]  = '{0, 1, 1, 3, 0, 4, 20, 1};
      tv[8]  = '{0, 1, 0, 3, 0, 3, 19, 1};
      tv[9]  = '{0, 1, 1, 3, 0, 2, 18, 1};
      tv[10] = '{0, 1, 0, 3, 0, 1, 17, 1};
      tv[11] = '{0, 1, 0, 3, 0, 0, 16, 1};

      for (int i = 0; i < 12; i++) begin
         reset = tv[i].rst;
         enable = tv[i].en;
         off_en0 = tv[i].trip;
         cyc();
         check($sformatf("vec%0d", i), act(0, 0),
               pk(tv[i].st, tv[i].b, tv[i].m, tv[i].o, tv[i].c));
         if (i == 7)
            check("fault_visible", 64'(a_ot0 != 0 && a_mt0 != 0), 64'd1);
      end
      off_en0 = 0;
      check("ch1_isolated", {46'd0, a_st1, a_cc1}, {46'd0, 2'd2, 16'd0});

      n = 0;
      while (a_st0 == 2'd3 && n < 40) begin
         cyc();
         n++;
      end
      check("off_len", 64'(n), 64'd16);
      check("reblank", act(0, 0), pk(1, 4, 10, 0, 1));

      // step restart from OFF, then step beating a trip in ON
      cfg_step_restart = 1;
      phase_ct = 8'd3;
      cyc();
      wait_st(0, 2, "wait_on_a");
      off_en0 = 1;
      cyc();
      off_en0 = 0;
      n = 0;
      while (a_ot0 != 10'd12 && n < 30) begin
         cyc();
         n++;
      end
      check("reach_off12", 64'(n < 30), 64'd1);
      phase_ct = 8'd4;
      cyc();
      check("step_off", act(0, 0), pk(1, 4, 10, 0, 2));
      wait_st(0, 2, "wait_on_a2");
      phase_ct = 8'd5;
      off_en0 = 1;
      cyc();
      off_en0 = 0;
      check("step_wins", act(0, 0), pk(1, 4, 10, 0, 2));

      // divided tick: off duration and enable drop mid-OFF
      cfg_step_restart = 0;
      cfg_off_time = 10'd3;
      reset = 1;
      cyc();
      reset = 0;
      check("reset_b", act(1, 0), pk(0, 0, 0, 0, 0));
      wait_st(1, 2, "wait_on_b");
      off_en0 = 1;
      cyc();
      off_en0 = 0;
      n = 0;
      while (b_st0 == 2'd3 && n < 40) begin
         n++;
         cyc();
      end
      check("off4_len", 64'(n >= 9 && n <= 15), 64'd1);
      wait_st(1, 2, "wait_on_b2");
      off_en0 = 1;
      cyc();
      off_en0 = 0;
      cyc();
      cyc();
      check("b_in_off", 64'(b_st0), 64'd3);
      enable = 0;
      cyc();
      check("disable_idle", act(1, 0), pk(0, 0, 0, 0, 2));

      // saturation on the 4-bit counter, then clear beating a trip
      cfg_blank = 8'd0;
      cfg_off_time = 10'd1;
      enable = 1;
      off_en0 = 1;
      for (int i = 0; i < 150; i++) cyc();
      check("sat", 64'(b_cc0), 64'd15);
      wait_st(1, 2, "wait_on_b3");
      stats_clear = 1;
      cyc();
      stats_clear = 0;
      check("clr_wins", {58'd0, b_st0, b_cc0}, {58'd0, 2'd3, 4'd0});
      off_en0 = 0;

      // randomized run against the model
      reset = 1;
      cyc();
      reset = 0;
      for (int i = 0; i < 4000; i++) begin
         if (i % 200 == 0) begin
            cfg_blank = 8'($urandom_range(0, 6));
            cfg_min_on = 8'($urandom_range(0, 15));
            cfg_off_time = 10'($urandom_range(0, 12));
            cfg_step_restart = 1'($urandom_range(0, 1));
         end
         enable = ($urandom_range(0, 99) < 97);
         off_en0 = ($urandom_range(0, 9) < 3);
         off_en1 = ($urandom_range(0, 9) < 3);
         stats_clear = ($urandom_range(0, 199) == 0);
         if ($urandom_range(0, 99) < 4) phase_ct = phase_ct + 8'd1;
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
